// File: rtl/i2c_reg_table_config.sv
// I2C master that writes a table of (register, value) pairs to one 7-bit slave.
// Runs once after reset and again on a start pulse or a rising edge of the interrupt.
module i2c_reg_table_config #(
    parameter int unsigned   CLK_HZ    = 50000000,
    parameter int unsigned   I2C_HZ    = 20000,
    parameter logic [6:0]    DEV_ADDR  = 7'h39,
    parameter int unsigned   NUM_REGS  = 31,
    parameter int unsigned   MAX_RETRY = 3,
    localparam int unsigned  AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSTART,
    input  logic          HDMI_TX_INT,
    output logic [AW-1:0] oROM_ADDR,
    input  logic [15:0]   iROM_DATA,
    inout  wire           I2C_SCLK,
    inout  wire           I2C_SDAT,
    output logic          oBUSY,
    output logic          oDONE,
    output logic          oERR,
    output logic [7:0]    oERR_IDX
);

    localparam int unsigned DIV = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CntLast  = CW'(DIV - 1);
    localparam logic [AW-1:0] LastIdx  = AW'(NUM_REGS - 1);
    localparam logic [3:0]    MaxRetry = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        StIdle, StLoad, StCapture, StStart, StByte, StAck, StStop, StGap, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    shift_q, shift_d;
    logic [15:0]   data_q, data_d;
    logic [3:0]    retry_q, retry_d;
    logic          nack_q, nack_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          scl_low_q, scl_low_d;
    logic          sda_low_q, sda_low_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    err_idx_q, err_idx_d;
    logic          pending_q, pending_d;
    logic          int_meta_q, int_sync_q, int_prev_q, int_rise_q;

    logic bus_active;
    logic hold;
    logic tick;

    assign bus_active = state_q inside {StStart, StByte, StAck, StStop, StGap};
    // Clock stretching: freeze the quarter timer while a released SCL still reads low.
    assign hold       = bus_active && !scl_low_q && !I2C_SCLK;
    assign tick       = bus_active && !hold && (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        data_d    = data_q;
        retry_d   = retry_q;
        nack_d    = nack_q;
        idx_d     = idx_q;
        scl_low_d = scl_low_q;
        sda_low_d = sda_low_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        pending_d = pending_q;

        if (!bus_active) begin
            cnt_d = '0;
            qtr_d = 2'd0;
        end else if (!hold) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
            if (tick) qtr_d = qtr_q + 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
                if (pending_q) begin
                    pending_d = 1'b0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    idx_d     = '0;
                    state_d   = StLoad;
                end
            end
            StLoad: state_d = StCapture;
            StCapture: begin
                data_d  = iROM_DATA;
                retry_d = 4'd0;
                state_d = StStart;
            end
            StStart: if (tick) begin
                unique case (qtr_q)
                    2'd0: sda_low_d = 1'b1;
                    2'd2: scl_low_d = 1'b1;
                    2'd3: begin
                        shift_d = {DEV_ADDR, 1'b0};
                        byte_d  = 2'd0;
                        bit_d   = 3'd0;
                        state_d = StByte;
                    end
                    default: ;
                endcase
            end
            StByte: if (tick) begin
                unique case (qtr_q)
                    2'd0: sda_low_d = !shift_q[7];
                    2'd1: scl_low_d = 1'b0;
                    2'd3: begin
                        scl_low_d = 1'b1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_d     = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = StAck;
                    end
                    default: ;
                endcase
            end
            StAck: if (tick) begin
                unique case (qtr_q)
                    2'd0: sda_low_d = 1'b0;
                    2'd1: scl_low_d = 1'b0;
                    2'd2: nack_d    = I2C_SDAT;
                    2'd3: begin
                        scl_low_d = 1'b1;
                        if (nack_q || byte_q == 2'd2) begin
                            state_d = StStop;
                        end else begin
                            byte_d  = byte_q + 2'd1;
                            shift_d = (byte_q == 2'd0) ? data_q[15:8] : data_q[7:0];
                            state_d = StByte;
                        end
                    end
                    default: ;
                endcase
            end
            StStop: if (tick) begin
                unique case (qtr_q)
                    2'd0: sda_low_d = 1'b1;
                    2'd1: scl_low_d = 1'b0;
                    2'd3: begin
                        sda_low_d = 1'b0;
                        state_d   = StGap;
                    end
                    default: ;
                endcase
            end
            StGap: if (tick && qtr_q == 2'd3) begin
                if (!nack_q) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = StLoad;
                    end
                end else if (retry_q < MaxRetry) begin
                    retry_d = retry_q + 4'd1;
                    state_d = StStart;
                end else begin
                    err_d     = 1'b1;
                    err_idx_d = 8'(idx_q);
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A new request wins over the clear so it is never lost.
        if (iSTART || int_rise_q) pending_d = 1'b1;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd0;
            byte_q     <= 2'd0;
            shift_q    <= 8'd0;
            data_q     <= 16'd0;
            retry_q    <= 4'd0;
            nack_q     <= 1'b0;
            idx_q      <= '0;
            scl_low_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= 8'd0;
            pending_q  <= 1'b1;
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
            int_prev_q <= 1'b0;
            int_rise_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            retry_q    <= retry_d;
            nack_q     <= nack_d;
            idx_q      <= idx_d;
            scl_low_q  <= scl_low_d;
            sda_low_q  <= sda_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_idx_q  <= err_idx_d;
            pending_q  <= pending_d;
            int_meta_q <= HDMI_TX_INT;
            int_sync_q <= int_meta_q;
            int_prev_q <= int_sync_q;
            int_rise_q <= int_sync_q & ~int_prev_q;
        end
    end

    assign I2C_SCLK  = scl_low_q ? 1'b0 : 1'bz;
    assign I2C_SDAT  = sda_low_q ? 1'b0 : 1'bz;
    assign oROM_ADDR = idx_q;
    assign oBUSY     = busy_q;
    assign oDONE     = done_q;
    assign oERR      = err_q;
    assign oERR_IDX  = err_idx_q;

endmodule

// File: tb/tb_i2c_reg_table_config.sv
// Directed bench: two-entry table, bus-level slave model with ACK/NACK and stretch control.
module tb_i2c_reg_table_config;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hdmi_int;
    logic [0:0]  rom_addr;
    logic [15:0] rom_data;
    wire         scl;
    wire         sda;
    logic        busy, done, err;
    logic [7:0]  err_idx;

    logic slv_scl_low = 1'b0;
    logic slv_sda_low = 1'b0;

    pullup (scl);
    pullup (sda);
    assign scl = slv_scl_low ? 1'b0 : 1'bz;
    assign sda = slv_sda_low ? 1'b0 : 1'bz;

    i2c_reg_table_config #(
        .CLK_HZ    (1600000),
        .I2C_HZ    (100000),
        .DEV_ADDR  (7'h39),
        .NUM_REGS  (2),
        .MAX_RETRY (3)
    ) u_dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iSTART      (start),
        .HDMI_TX_INT (hdmi_int),
        .oROM_ADDR   (rom_addr),
        .iROM_DATA   (rom_data),
        .I2C_SCLK    (scl),
        .I2C_SDAT    (sda),
        .oBUSY       (busy),
        .oDONE       (done),
        .oERR        (err),
        .oERR_IDX    (err_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= (rom_addr == 1'b0) ? 16'h4110 : 16'h9803;

    // Run bookkeeping
    int   run_count = 0;
    int   busy_cycles = 0;
    logic busy_prev = 1'b0;
    always @(posedge clk) begin
        busy_prev <= busy;
        if (busy && !busy_prev) run_count <= run_count + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
    end

    // Slave model; frames are logged as {byte count, b0, b1, b2}
    logic [31:0] frames[$];
    logic        p_scl = 1'b1, p_sda = 1'b1;
    logic        in_frame = 1'b0, ackph = 1'b0;
    int          bitc = 0, nb = 0;
    logic [7:0]  sh = 8'd0;
    logic [7:0]  fb [3];
    int          stretch_left = 0;
    int          nack_count = 0, stretch_count = 0;
    int          nack_mode = 0, nack_base = 0, stretch_base = 0;
    logic        stretch_en = 1'b0;

    function automatic logic want_nack(input int n, input logic [7:0] b);
        if (nack_mode == 1) return (n == 1) && (b == 8'h98);
        if (nack_mode == 2) return (n == 0) && (nack_count == nack_base);
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        p_scl <= scl;
        p_sda <= sda;
        if (stretch_left > 0) begin
            stretch_left <= stretch_left - 1;
            if (stretch_left == 1) slv_scl_low <= 1'b0;
        end
        if (p_scl && scl && p_sda && !sda) begin
            in_frame    <= 1'b1;
            bitc        <= 0;
            nb          <= 0;
            ackph       <= 1'b0;
            slv_sda_low <= 1'b0;
            fb[0] <= 8'd0; fb[1] <= 8'd0; fb[2] <= 8'd0;
        end else if (p_scl && scl && !p_sda && sda) begin
            if (in_frame) frames.push_back({nb[7:0], fb[0], fb[1], fb[2]});
            in_frame <= 1'b0;
        end else if (in_frame && !p_scl && scl && !ackph) begin
            sh   <= {sh[6:0], sda};
            bitc <= bitc + 1;
        end else if (in_frame && p_scl && !scl) begin
            if (ackph) begin
                ackph       <= 1'b0;
                slv_sda_low <= 1'b0;
                bitc        <= 0;
            end else if (bitc == 8) begin
                if (nb < 3) fb[nb] <= sh;
                nb    <= nb + 1;
                ackph <= 1'b1;
                if (want_nack(nb, sh)) nack_count <= nack_count + 1;
                else slv_sda_low <= 1'b1;
            end else if (stretch_en && nb == 2 && bitc == 3 && stretch_count == stretch_base) begin
                slv_scl_low   <= 1'b1;
                stretch_left  <= 2 * DIV + 50;
                stretch_count <= stretch_count + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int near(input int v, input int t, input int tol);
        return (v >= t - tol && v <= t + tol) ? t : v;
    endfunction

    task automatic run_wait(input string tag, input int budget);
        bit rose = 1'b0;
        bit fell = 1'b0;
        for (int i = 0; i < 20 && !rose; i++) begin
            @(negedge clk);
            rose = busy;
        end
        for (int i = 0; i < budget && rose && !fell; i++) begin
            @(negedge clk);
            fell = !busy;
        end
        check({tag, "_end"}, 32'(fell), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    localparam logic [31:0] E0    = 32'h03724110;
    localparam logic [31:0] E1    = 32'h03729803;
    localparam logic [31:0] ENACK = 32'h02729800;
    localparam logic [31:0] EADDR = 32'h01720000;

    int f0, r0, c0, s0;
    bit reached;

    initial begin
        rst = 1'b1; start = 1'b0; hdmi_int = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_idx", 32'(err_idx), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);

        // Automatic first run
        f0 = frames.size(); r0 = run_count; c0 = busy_cycles;
        rst = 1'b0;
        run_wait("basic", 3000);
        @(negedge clk);
        check("basic_done", 32'(done), 32'd1);
        check("basic_err", 32'(err), 32'd0);
        check("basic_len", 32'(near(busy_cycles - c0, 964, 3)), 32'd964);
        check("basic_runs", 32'(run_count - r0), 32'd1);
        check("basic_nframes", 32'(frames.size() - f0), 32'd2);
        check("basic_f0", frames[f0], E0);
        check("basic_f1", frames[f0 + 1], E1);

        // Clock stretch on bit 3 of the value byte
        stretch_base = stretch_count; stretch_en = 1'b1;
        f0 = frames.size(); c0 = busy_cycles; s0 = stretch_count;
        pulse_start();
        run_wait("stretch", 3000);
        stretch_en = 1'b0;
        @(negedge clk);
        check("stretch_hit", 32'(stretch_count - s0), 32'd1);
        check("stretch_len", 32'(near(busy_cycles - c0, 1014, DIV)), 32'd1014);
        check("stretch_nframes", 32'(frames.size() - f0), 32'd2);
        check("stretch_f0", frames[f0], E0);
        check("stretch_f1", frames[f0 + 1], E1);

        // One NACK on the first address byte
        nack_base = nack_count; nack_mode = 2;
        f0 = frames.size();
        pulse_start();
        run_wait("nack1", 3000);
        nack_mode = 0;
        @(negedge clk);
        check("nack1_done", 32'(done), 32'd1);
        check("nack1_err", 32'(err), 32'd0);
        check("nack1_nframes", 32'(frames.size() - f0), 32'd3);
        check("nack1_f0", frames[f0], EADDR);
        check("nack1_f1", frames[f0 + 1], E0);
        check("nack1_f2", frames[f0 + 2], E1);

        // Entry 1 NACKed on every attempt
        nack_mode = 1;
        f0 = frames.size();
        pulse_start();
        run_wait("nackp", 6000);
        nack_mode = 0;
        @(negedge clk);
        check("nackp_err", 32'(err), 32'd1);
        check("nackp_err_idx", 32'(err_idx), 32'd1);
        check("nackp_done", 32'(done), 32'd0);
        check("nackp_nframes", 32'(frames.size() - f0), 32'd5);
        check("nackp_f0", frames[f0], E0);
        check("nackp_f1", frames[f0 + 1], ENACK);
        check("nackp_f4", frames[f0 + 4], ENACK);

        // Interrupt edge plus start pulse during entry 0: exactly one extra run
        f0 = frames.size(); r0 = run_count;
        pulse_start();
        repeat (200) @(negedge clk);
        hdmi_int = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 3000 && !reached; i++) begin
            @(negedge clk);
            reached = !busy;
        end
        check("int_first_end", 32'(reached), 32'd1);
        run_wait("int_second", 3000);
        hdmi_int = 1'b0;
        repeat (100) @(negedge clk);
        check("int_runs", 32'(run_count - r0), 32'd2);
        check("int_nframes", 32'(frames.size() - f0), 32'd4);
        check("int_done", 32'(done), 32'd1);

        // Reset during bit 5 of the register byte
        pulse_start();
        reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge clk);
            reached = in_frame && nb == 1 && bitc == 5 && !scl;
        end
        check("mrst_reach", 32'(reached), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_scl_z", 32'(scl), 32'd1);
        check("mrst_sda_z", 32'(sda), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        f0 = frames.size();
        rst = 1'b0;
        run_wait("mrst", 3000);
        @(negedge clk);
        check("mrst_done", 32'(done), 32'd1);
        check("mrst_nframes", 32'(frames.size() - f0), 32'd2);
        check("mrst_f0", frames[f0], E0);
        check("mrst_f1", frames[f0 + 1], E1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
